bcd_score_counter: RTL
======================

Name: bcd_score_counter

Overview:
Parametrised N-digit BCD score counter, the successor to the fixed two-digit score block. Supports increment and decrement, a selectable saturate or wrap mode, overflow/underflow flags, and a running high-score register. It sits between the game-control FSM, which supplies one-shot increment/decrement strobes, and the seven-segment display decoders, which consume the BCD digit outputs.

Parameters:
NUM_DIGITS, 2, number of BCD digits (1..8); score range is 0 .. 10^NUM_DIGITS-1.
SATURATE, 1, 1 = clamp at max/zero; 0 = wrap around modulo 10^NUM_DIGITS.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset; clears score and high score.
score_reconfig  input  1  synchronous clear of score to zero; high score is retained.
score_enable  input  1  when low, score holds and strobes are ignored.
increment  input  1  count-up strobe, sampled every clk.
decrement  input  1  count-down strobe, sampled every clk.
score_bcd  output  4*NUM_DIGITS  current score; digit 0 (ones) in bits [3:0].
high_bcd  output  4*NUM_DIGITS  highest score reached since rst.
overflow  output  1  one-cycle pulse when an increment hits or crosses the max.
underflow  output  1  one-cycle pulse when a decrement hits or crosses zero.
new_high  output  1  one-cycle pulse when high_bcd is updated.

Behaviour:
- Reset (rst=1, asynchronous): score_bcd=0, high_bcd=0, overflow=underflow=new_high=0.
- Priority per cycle, highest first: rst > score_reconfig > !score_enable (hold) > strobes.
- score_reconfig=1: score_bcd<=0 on the next edge; flags are 0 that cycle; high_bcd unchanged.
- Each cycle with enable=1 and exactly one strobe high = one step. The count is level-sampled; the upstream block supplies one-shots, and a strobe held for k cycles gives k steps.
- increment and decrement both high: no change, no flags.
- Digits are always valid BCD (0-9). The carry/borrow ripples combinationally across all digits in one cycle, and the result is registered: 1-cycle latency from strobe to score_bcd.
- Digit i increments when all lower digits are 9. It decrements when all lower digits are 0.
- At max (all digits 9) with increment:
  - SATURATE=1: hold at max, overflow=1.
  - SATURATE=0: go to 0, overflow=1.
- At zero with decrement:
  - SATURATE=1: hold at 0, underflow=1.
  - SATURATE=0: go to max, underflow=1.
- overflow and underflow are registered and assert in the same cycle the new score_bcd appears.
- High score:
  - On each edge, if the registered score_bcd > high_bcd (unsigned compare; BCD ordering is valid), then high_bcd <= score_bcd and new_high=1 for that cycle.
  - So high_bcd lags score_bcd by one cycle.
  - A wrap to 0 or a decrement never lowers high_bcd.
- score_reconfig asserted mid-count discards any concurrent strobe.
- rst asserted at any time clears everything immediately, independent of clk.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset, then enable=1 and pulse increment 12 times (NUM_DIGITS=2) -> score_bcd=8'h12, high_bcd=8'h12 one cycle later; new_high pulses after each step.
- From 8'h99, SATURATE=1, increment -> score stays 8'h99 and overflow pulses once. With SATURATE=0 -> score=8'h00, overflow=1, high_bcd stays 8'h99.
- From 8'h00, decrement: SATURATE=1 -> stays 8'h00, underflow=1. SATURATE=0 -> 8'h99, underflow=1.
- From 8'h40, decrement -> 8'h39 (borrow across digits). increment and decrement together -> 8'h39 unchanged, no flags. enable=0 with increment -> unchanged.
- Score 8'h57, high 8'h57, then score_reconfig with a concurrent increment -> score=8'h00, high_bcd=8'h57, no new_high. Re-count to 8'h58 -> high becomes 8'h58 with a new_high pulse.
- rst asserted mid-sequence between clk edges -> all outputs 0 immediately. NUM_DIGITS=4 run: increment from 16'h0999 -> 16'h1000.

Source files
------------

// File: rtl/bcd_score_counter.sv
// N-digit BCD score counter: up/down, saturate or wrap, running high score; 1-cycle latency.
// No backpressure: strobes are consumed every cycle, and score_enable low holds all state.
module bcd_score_counter #(
  parameter int NUM_DIGITS = 2,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    score_reconfig,
  input  logic                    score_enable,
  input  logic                    increment,
  input  logic                    decrement,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    new_high
);
  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0]          inc_val;
  logic [W-1:0]          dec_val;
  logic [W-1:0]          score_d;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS:0]   borrow;
  logic                  at_max;
  logic                  at_zero;
  logic                  ovf_d;
  logic                  unf_d;

  // Carry runs while lower digits are all 9, borrow while they are all 0.
  always_comb begin
    carry     = '0;
    borrow    = '0;
    inc_val   = '0;
    dec_val   = '0;
    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry[i])
        inc_val[4*i +: 4] = (score_bcd[4*i +: 4] == 4'd9) ? 4'd0 : score_bcd[4*i +: 4] + 4'd1;
      else
        inc_val[4*i +: 4] = score_bcd[4*i +: 4];
      if (borrow[i])
        dec_val[4*i +: 4] = (score_bcd[4*i +: 4] == 4'd0) ? 4'd9 : score_bcd[4*i +: 4] - 4'd1;
      else
        dec_val[4*i +: 4] = score_bcd[4*i +: 4];
      carry[i+1]  = carry[i]  && (score_bcd[4*i +: 4] == 4'd9);
      borrow[i+1] = borrow[i] && (score_bcd[4*i +: 4] == 4'd0);
    end
  end

  assign at_max  = carry[NUM_DIGITS];
  assign at_zero = borrow[NUM_DIGITS];

  // Wrap falls out of the digit logic: all-9 + 1 gives 0 and 0 - 1 gives all-9.
  always_comb begin
    score_d = score_bcd;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (score_reconfig) begin
      score_d = '0;
    end else if (score_enable && increment && !decrement) begin
      ovf_d   = at_max;
      score_d = (at_max && SATURATE) ? score_bcd : inc_val;
    end else if (score_enable && decrement && !increment) begin
      unf_d   = at_zero;
      score_d = (at_zero && SATURATE) ? score_bcd : dec_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_bcd <= '0;
      high_bcd  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      new_high  <= 1'b0;
    end else begin
      score_bcd <= score_d;
      overflow  <= ovf_d;
      underflow <= unf_d;
      // Packed BCD orders like binary, so a plain unsigned compare suffices.
      if (score_bcd > high_bcd) begin
        high_bcd <= score_bcd;
        new_high <= 1'b1;
      end else begin
        new_high <= 1'b0;
      end
    end
  end
endmodule
